// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Build option: DMEM_PARITY_EN widens each stored word by one even-parity bit.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 4;
   localparam int CNT_W       = 2;

`ifdef DMEM_PARITY_EN
   localparam int DATA_W = 33;
`else
   localparam int DATA_W = 32;
`endif

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; one read or write per clock, read returns the old contents.
// Build option: DMEM_PARITY_EN makes the word 33 bits (parity in bit 32).
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] idx,
   input  logic [DATA_W-1:0]     din,
   output logic [DATA_W-1:0]     dout
);

   logic [DATA_W-1:0] r_mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[idx] <= din;
      end
      dout <= r_mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one word access, stalls the pipeline for LATENCY cycles.
// Build option: DMEM_PARITY_EN adds parity_inject and a live parity_err output.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int LATENCY    = 2   // legal range LATENCY_MIN..LATENCY_MAX
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_ena,
   input  logic        dmem_w_cs,
   input  logic        dmem_r_cs,
   input  logic        dmem_wena,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
`ifdef DMEM_PARITY_EN
   input  logic        parity_inject,
`endif
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        stall,
   output logic        addr_err,
   output logic        parity_err,
   output state_t      dbg_state
);

   // Handshake: a request is taken in IDLE when dmem_ena=1 with exactly one select
   // and a word-aligned address. stall is high from that cycle until DONE; the
   // pipeline holds its inputs stable meanwhile and advances on the DONE edge.

   state_t                r_state, w_next_state;
   logic [CNT_W-1:0]      r_cnt, w_next_cnt;
   op_t                   r_op;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [31:0]           r_wdata;
   logic                  r_wena;
   logic                  r_pinj;
   logic [31:0]           r_rdata_hold;

   logic [ADDR_WIDTH-1:0] w_in_idx;
   logic [ADDR_WIDTH-1:0] w_arr_idx;
   logic                  w_reject;
   logic                  w_accept;
   logic                  w_load;
   logic                  w_we;
   logic [DATA_W-1:0]     w_din;
   logic [DATA_W-1:0]     w_dout;
   logic                  w_in_pinj;
   logic                  w_unused_addr;

   assign w_in_idx      = addr[ADDR_WIDTH+1:2];
   assign w_unused_addr = ^addr[31:ADDR_WIDTH+2];
   assign w_reject      = dmem_ena & ((|addr[1:0]) | (dmem_w_cs & dmem_r_cs));
   assign w_accept      = dmem_ena & (dmem_w_cs ^ dmem_r_cs) & ~(|addr[1:0]);

`ifdef DMEM_PARITY_EN
   assign w_in_pinj  = parity_inject;
   assign w_din      = {even_parity(r_wdata) ^ r_pinj, r_wdata};
   assign parity_err = rdata_valid & (even_parity(w_dout[31:0]) != w_dout[32]);
`else
   assign w_in_pinj  = 1'b0;
   assign w_din      = r_wdata;
   assign parity_err = 1'b0;
`endif

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk  (clk),
      .we   (w_we),
      .idx  (w_arr_idx),
      .din  (w_din),
      .dout (w_dout)
   );

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_arr_idx    = r_idx;
      w_load       = 1'b0;
      w_we         = 1'b0;
      stall        = 1'b0;
      addr_err     = 1'b0;
      rdata_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            // Present the incoming index so a LATENCY=1 read has data in DONE.
            w_arr_idx = w_in_idx;
            if (w_reject) begin
               addr_err = 1'b1;
            end else if (w_accept) begin
               w_load       = 1'b1;
               stall        = 1'b1;
               w_next_cnt   = CNT_W'(LATENCY - 1);
               w_next_state = (LATENCY > 1) ? BUSY : DONE;
            end
         end
         BUSY: begin
            stall      = 1'b1;
            w_next_cnt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            w_next_state = IDLE;
            w_we         = (r_op == OP_WR) & r_wena;
            rdata_valid  = (r_op == OP_RD);
         end
         default: w_next_state = IDLE;
      endcase
      if (rst) begin
         w_next_state = IDLE;
         w_next_cnt   = '0;
         w_load       = 1'b0;
         w_we         = 1'b0;
         stall        = 1'b0;
         addr_err     = 1'b0;
         rdata_valid  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_op         <= OP_RD;
         r_idx        <= '0;
         r_wdata      <= '0;
         r_wena       <= 1'b0;
         r_pinj       <= 1'b0;
         r_rdata_hold <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_load) begin
            r_op    <= dmem_w_cs ? OP_WR : OP_RD;
            r_idx   <= w_in_idx;
            r_wdata <= wdata;
            r_wena  <= dmem_wena;
            r_pinj  <= w_in_pinj;
         end
         if (rdata_valid) begin
            r_rdata_hold <= w_dout[31:0];
         end
      end
   end

   assign rdata     = rdata_valid ? w_dout[31:0] : r_rdata_hold;
   assign dbg_state = r_state;

endmodule
